// File: rtl/pin_bank_pkg.sv
// Shared constants for the pin bank: parameter limits and IOBUF tristate encoding.
package pin_bank_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int DEB_W_DEF       = 16;

   // IOBUF T polarity: 1 releases the pad (input), 0 drives it.
   localparam logic TRI_INPUT = 1'b1;

endpackage

// File: rtl/pin_filter.sv
// One pin's input conditioning: synchroniser, debounce, filtered level and edge pulses.
module pin_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pin_i,
   input  logic             priming,
   input  logic             deb_en,
   input  logic [DEB_W-1:0] deb_limit,
   output logic             data_in,
   output logic             rise,
   output logic             fall
);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync;
   logic                   stable;
   logic                   stable_d;
   logic [DEB_W-1:0]       cnt;
   logic [DEB_W-1:0]       lim_m1;
   logic                   bypass;

   assign sync   = sync_ff[SYNC_STAGES-1];
   assign bypass = ~deb_en | (deb_limit == '0);
   assign lim_m1 = deb_limit - DEB_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], pin_i};
      end
   end

   // Priming loads both stable and stable_d so a level held through reset never looks like an edge.
   // The >= compare makes a lowered deb_limit take effect on the very next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
      end else if (priming) begin
         stable   <= sync;
         stable_d <= sync;
         cnt      <= '0;
      end else begin
         stable_d <= stable;
         if (bypass) begin
            stable <= sync;
            cnt    <= '0;
         end else if (sync == stable) begin
            cnt <= '0;
         end else if (cnt >= lim_m1) begin
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + DEB_W'(1);
         end
      end
   end

   assign data_in = stable;
   assign rise    = stable & ~stable_d & ~priming;
   assign fall    = ~stable & stable_d & ~priming;

endmodule

// File: rtl/pin_bank_ctrl.sv
// Bank of NUM_PINS bidirectional pins: registered output/tristate, filtered inputs, sticky edge irq.
module pin_bank_ctrl
   import pin_bank_pkg::*;
#(
   parameter int NUM_PINS    = 20,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = DEB_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_PINS-1:0] data_out,
   input  logic [NUM_PINS-1:0] tri_ctrl,
   output logic [NUM_PINS-1:0] pin_o,
   output logic [NUM_PINS-1:0] pin_t,
   input  logic [NUM_PINS-1:0] pin_i,
   input  logic [NUM_PINS-1:0] deb_en,
   input  logic [DEB_W-1:0]    deb_limit,
   input  logic [NUM_PINS-1:0] rise_en,
   input  logic [NUM_PINS-1:0] fall_en,
   input  logic [NUM_PINS-1:0] irq_mask,
   input  logic [NUM_PINS-1:0] irq_clr,
   output logic [NUM_PINS-1:0] data_in,
   output logic [NUM_PINS-1:0] rise,
   output logic [NUM_PINS-1:0] fall,
   output logic [NUM_PINS-1:0] irq_status,
   output logic                irq
);

   localparam int PRIME_CYC = SYNC_STAGES + 1;
   localparam int PRIME_W   = $clog2(PRIME_CYC + 1);

   logic [PRIME_W-1:0] prime_cnt;
   logic               priming;

   // One shared window after reset release while the synchronisers fill.
   assign priming = (prime_cnt != PRIME_W'(PRIME_CYC));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prime_cnt <= '0;
      end else if (priming) begin
         prime_cnt <= prime_cnt + PRIME_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pin_o <= '0;
         pin_t <= {NUM_PINS{TRI_INPUT}};
      end else begin
         pin_o <= data_out;
         pin_t <= tri_ctrl;
      end
   end

   for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
      pin_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_W       (DEB_W)
      ) u_filt (
         .clk       (clk),
         .reset     (reset),
         .pin_i     (pin_i[g]),
         .priming   (priming),
         .deb_en    (deb_en[g]),
         .deb_limit (deb_limit),
         .data_in   (data_in[g]),
         .rise      (rise[g]),
         .fall      (fall[g])
      );
   end

   // Set terms are ORed after the clear so a same-cycle edge survives irq_clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_status <= '0;
         irq        <= 1'b0;
      end else begin
         irq_status <= (irq_status & ~irq_clr) | (rise & rise_en) | (fall & fall_en);
         irq        <= |(irq_status & irq_mask);
      end
   end

endmodule

// File: tb/tb_pin_bank_ctrl.sv
// Directed bench for pin_bank_ctrl: vector tables for the output/bypass paths, sequences for corner cases.
module tb_pin_bank_ctrl;

   localparam int N = 20;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  data_out, tri_ctrl, pin_o, pin_t, pin_i, deb_en;
   logic [DW-1:0] deb_limit;
   logic [N-1:0]  rise_en, fall_en, irq_mask, irq_clr;
   logic [N-1:0]  data_in, rise, fall, irq_status;
   logic          irq;

   int n_cmp = 0;
   int n_bad = 0;

   pin_bank_ctrl #(.NUM_PINS(N), .SYNC_STAGES(2), .DEB_W(DW)) dut (
      .clk(clk), .reset(reset), .data_out(data_out), .tri_ctrl(tri_ctrl),
      .pin_o(pin_o), .pin_t(pin_t), .pin_i(pin_i), .deb_en(deb_en),
      .deb_limit(deb_limit), .rise_en(rise_en), .fall_en(fall_en),
      .irq_mask(irq_mask), .irq_clr(irq_clr), .data_in(data_in),
      .rise(rise), .fall(fall), .irq_status(irq_status), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] tri_v;
      logic [N-1:0] dout;
      logic [N-1:0] exp_o;
      logic [N-1:0] exp_t;
   } out_vec_t;

   typedef struct {
      logic [N-1:0] pin;
      logic [N-1:0] exp_in;
   } in_vec_t;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   out_vec_t ov[4];
   in_vec_t  iv[4];

   initial begin
      logic         seen;
      logic [N-1:0] prev;

      ov[0] = '{20'hFFFFF, 20'h5A5A5, 20'h5A5A5, 20'hFFFFF};
      ov[1] = '{20'h0F0F0, 20'h12345, 20'h12345, 20'h0F0F0};
      ov[2] = '{20'h00001, 20'hFFFFF, 20'hFFFFF, 20'h00001};
      ov[3] = '{20'h00000, 20'h00000, 20'h00000, 20'h00000};

      iv[0] = '{20'hFFFFF, 20'hFFFFF};
      iv[1] = '{20'h12345, 20'h12345};
      iv[2] = '{20'h00000, 20'h00000};
      iv[3] = '{20'h00020, 20'h00020};

      reset     = 1'b1;
      data_out  = 20'hA5A5A;
      tri_ctrl  = 20'h00000;
      pin_i     = 20'h00020;
      deb_en    = '0;
      deb_limit = '0;
      rise_en   = '1;
      fall_en   = '1;
      irq_mask  = '0;
      irq_clr   = '0;

      // Reset state
      tick(2);
      chk("rst_pin_t", pin_t, 20'hFFFFF);
      chk("rst_pin_o", pin_o, 0);
      chk("rst_data_in", data_in, 0);
      chk("rst_status", irq_status, 0);
      chk("rst_irq", irq, 0);

      reset = 1'b0;
      tick(1);
      chk("out_pin_o", pin_o, 20'hA5A5A);
      chk("out_pin_t", pin_t, 0);

      // Pin 5 held high through reset: primed, no rise
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (rise[5] !== 1'b0) seen = 1'b1;
         tick(1);
      end
      chk("prime_no_rise5", seen, 0);
      chk("prime_data_in", data_in, 20'h00020);
      chk("prime_status", irq_status, 0);

      // Output path table
      prev = 20'hA5A5A;
      for (int i = 0; i < 4; i++) begin
         tri_ctrl = ov[i].tri_v;
         data_out = ov[i].dout;
         #1;
         chk($sformatf("out_hold_%0d", i), pin_o, prev);
         tick(1);
         chk($sformatf("out_o_%0d", i), pin_o, ov[i].exp_o);
         chk($sformatf("out_t_%0d", i), pin_t, ov[i].exp_t);
         prev = ov[i].exp_o;
      end

      // Bypass input path table: SYNC_STAGES+1 latency
      prev = 20'h00020;
      for (int i = 0; i < 4; i++) begin
         pin_i = iv[i].pin;
         tick(2);
         chk($sformatf("byp_early_%0d", i), data_in, prev);
         tick(1);
         chk($sformatf("byp_in_%0d", i), data_in, iv[i].exp_in);
         prev = iv[i].exp_in;
      end
      tick(2);
      irq_clr = '1;
      tick(1);
      irq_clr = '0;
      tick(2);
      chk("clr_all_status", irq_status, 0);
      chk("clr_all_irq", irq, 0);

      // Pin 3 rise, bypass
      irq_mask = 20'h00008;
      pin_i[3] = 1'b1;
      tick(2);
      chk("p3_early", data_in[3], 0);
      tick(1);
      chk("p3_data_in", data_in[3], 1);
      chk("p3_rise", rise[3], 1);
      chk("p3_status_pre", irq_status[3], 0);
      tick(1);
      chk("p3_rise_end", rise[3], 0);
      chk("p3_status", irq_status[3], 1);
      chk("p3_irq_pre", irq, 0);
      tick(1);
      chk("p3_irq", irq, 1);
      irq_clr[3] = 1'b1;
      tick(1);
      irq_clr[3] = 1'b0;
      chk("p3_clr", irq_status[3], 0);
      tick(1);
      chk("p3_irq_drop", irq, 0);

      // Pin 0 debounce, limit 8: a 7-cycle pulse is rejected
      deb_en[0] = 1'b1;
      deb_limit = 16'd8;
      seen = 1'b0;
      pin_i[0] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         if (data_in[0] !== 1'b0 || rise[0] !== 1'b0) seen = 1'b1;
      end
      pin_i[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (data_in[0] !== 1'b0 || rise[0] !== 1'b0) seen = 1'b1;
      end
      chk("deb_glitch7", seen, 0);

      // 8 stable cycles accepted exactly 8 cycles after sync rises
      pin_i[0] = 1'b1;
      tick(2);
      tick(7);
      chk("deb_early", data_in[0], 0);
      tick(1);
      chk("deb_accept", data_in[0], 1);
      chk("deb_rise", rise[0], 1);

      // Lowering deb_limit mid-count accepts on the next cycle
      pin_i[0] = 1'b0;
      tick(6);
      chk("lim_hold", data_in[0], 1);
      deb_limit = 16'd3;
      tick(1);
      chk("lim_accept", data_in[0], 0);
      chk("lim_fall", fall[0], 1);
      deb_limit = 16'd8;

      // Pin 7: fall coincides with irq_clr, set wins
      pin_i[7] = 1'b1;
      tick(4);
      chk("p7_high", data_in[7], 1);
      irq_clr[7] = 1'b1;
      tick(1);
      irq_clr[7] = 1'b0;
      irq_mask = 20'h00088;
      tick(1);
      chk("p7_clr_pre", irq_status[7], 0);
      chk("p7_irq_pre", irq, 0);
      pin_i[7] = 1'b0;
      tick(3);
      chk("p7_fall", fall[7], 1);
      irq_clr[7] = 1'b1;
      tick(1);
      chk("p7_set_wins", irq_status[7], 1);
      tick(1);
      chk("p7_cleared", irq_status[7], 0);
      chk("p7_irq", irq, 1);
      irq_clr[7] = 1'b0;
      tick(1);
      chk("p7_irq_drop", irq, 0);

      // Reset mid-debounce (cnt=5 of 8)
      pin_i[0] = 1'b1;
      tick(7);
      chk("mid_pre", data_in[0], 0);
      reset = 1'b1;
      #1;
      chk("mid_rst_data_in", data_in, 0);
      chk("mid_rst_pin_t", pin_t, 20'hFFFFF);
      chk("mid_rst_status", irq_status, 0);
      pin_i[0] = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(6);
      chk("mid_primed", data_in, 20'h00028);
      pin_i[0] = 1'b1;
      tick(9);
      chk("mid_restart_early", data_in[0], 0);
      tick(1);
      chk("mid_restart_accept", data_in[0], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
